// File: rtl/dps_sci_ex.sv
// dps_sci_ex: DPS bus SCI with UART TX/RX engines, FIFOs, baud divisor and level interrupts
module dps_sci_ex_fifo #(
   parameter int W = 8,
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic [5:0]   count,
   output logic         full,
   output logic         empty,
   output logic         do_push,
   output logic         do_pop
);
   logic [W-1:0] mem_q [2**N];
   logic [N-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [N:0]   cnt_q, cnt_d;
   always_comb begin
      empty   = cnt_q == '0;
      full    = cnt_q[N];
      do_pop  = pop & ~empty & ~flush;
      do_push = push & (~full | do_pop) & ~flush;
      wp_d    = flush ? '0 : wp_q + N'(do_push);
      rp_d    = flush ? '0 : rp_q + N'(do_pop);
      cnt_d   = flush ? '0 : cnt_q + (N+1)'(do_push) - (N+1)'(do_pop);
      count   = 6'(cnt_q);
      rdata   = mem_q[rp_q];
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
   end
   always_ff @(posedge clk) if (do_push) mem_q[wp_q] <= wdata;
endmodule

module dps_sci_ex #(
   parameter int                     P_FIFO_DEPTH_N = 4,
   parameter int                     P_DIV_WIDTH    = 16,
   parameter logic [P_DIV_WIDTH-1:0] P_BAUDDIV_RST  = 16'd433
) (
   input  logic        iIF_CLOCK,
   input  logic        inRESET,
   input  logic        iREQ_VALID,
   output logic        oREQ_BUSY,
   input  logic        iREQ_RW,
   input  logic [2:0]  iREQ_ADDR,
   input  logic [31:0] iREQ_DATA,
   output logic        oREQ_VALID,
   output logic [31:0] oREQ_DATA,
   output logic        oIRQ_VALID,
   input  logic        iIRQ_ACK,
   output logic        oLSFLAGS_TIRE_IRQ,
   output logic        oLSFLAGS_RIRE_IRQ,
   output logic        oUART_TXD,
   input  logic        iUART_RXD
);
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} bit_st_e;
   typedef enum logic [1:0] {I_IDLE, I_PEND, I_WAIT} irq_st_e;
   logic [20:0]            cfg_q, cfg_d;
   logic [3:0]             stat_q, stat_d;
   logic [P_DIV_WIDTH-1:0] div_q, div_d, div_eff;
   logic                   rvalid_q, rvalid_d;
   logic [31:0]            rdata_q, rdata_d, rx_word, stat_word, rd_val;
   bit_st_e                tx_st_q, tx_st_d, rx_st_q, rx_st_d;
   logic [P_DIV_WIDTH-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic [2:0]             tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
   logic [7:0]             tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
   logic                   txd_q, txd_d, rx_pe_q, rx_pe_d;
   logic [2:0]             rxd_q, rxd_d;
   irq_st_e                irq_q, irq_d;
   logic wr, rd, wr_cfg, wr_stat, wr_div, tx_wr, rx_rd, tclr, rclr;
   logic ten, ren, pen, podd, stop2, tie, rie;
   logic [5:0] txthr, rxthr, tx_count, rx_count;
   logic [7:0] tx_rdata;
   logic [9:0] rx_rdata;
   logic tx_full, tx_empty, tx_do_push, tx_do_pop, tx_pop, tx_ovf;
   logic rx_full, rx_empty, rx_do_push, rx_do_pop, rx_push, rx_fe, rx_ovf;
   logic rx_line, rx_prev, tx_src, rx_src, unused_bits;
   assign wr      = iREQ_VALID & iREQ_RW;
   assign rd      = iREQ_VALID & ~iREQ_RW;
   assign tx_wr   = wr & (iREQ_ADDR == 3'd0);
   assign rx_rd   = rd & (iREQ_ADDR == 3'd1);
   assign wr_cfg  = wr & (iREQ_ADDR == 3'd2);
   assign wr_stat = wr & (iREQ_ADDR == 3'd3);
   assign wr_div  = wr & (iREQ_ADDR == 3'd4);
   assign tclr    = wr_cfg & iREQ_DATA[7];
   assign rclr    = wr_cfg & iREQ_DATA[8];
   assign {ten, ren, pen, podd, stop2, tie, rie} = {cfg_q[0], cfg_q[1], cfg_q[2], cfg_q[3], cfg_q[4], cfg_q[5], cfg_q[6]};
   assign txthr   = cfg_q[14:9];
   assign rxthr   = cfg_q[20:15];
   assign div_eff = (div_q < P_DIV_WIDTH'(3)) ? P_DIV_WIDTH'(3) : div_q;
   assign rx_line = rxd_q[1];
   assign rx_prev = rxd_q[2];
   assign tx_ovf  = tx_wr & ~tx_do_push & ~tclr;
   assign rx_ovf  = rx_push & ~rx_do_push & ~rclr;
   assign tx_src  = tie & (tx_count <= txthr);
   assign rx_src  = rie & (((rxthr != 6'd0) & (rx_count >= rxthr)) | (|stat_q[2:0]));
   assign unused_bits = ^{iREQ_DATA[31:21], rx_full, tx_do_pop, rx_do_pop};
   assign oREQ_BUSY         = tx_full;
   assign oREQ_VALID        = rvalid_q;
   assign oREQ_DATA         = rdata_q;
   assign oIRQ_VALID        = irq_q == I_PEND;
   assign oLSFLAGS_TIRE_IRQ = tx_src;
   assign oLSFLAGS_RIRE_IRQ = rx_src;
   assign oUART_TXD         = txd_q;

   dps_sci_ex_fifo #(.W(8), .N(P_FIFO_DEPTH_N)) u_txf (
      .clk(iIF_CLOCK), .rst_n(inRESET), .flush(tclr), .push(tx_wr), .pop(tx_pop),
      .wdata(iREQ_DATA[7:0]), .rdata(tx_rdata), .count(tx_count), .full(tx_full),
      .empty(tx_empty), .do_push(tx_do_push), .do_pop(tx_do_pop));

   dps_sci_ex_fifo #(.W(10), .N(P_FIFO_DEPTH_N)) u_rxf (
      .clk(iIF_CLOCK), .rst_n(inRESET), .flush(rclr), .push(rx_push), .pop(rx_rd),
      .wdata({rx_pe_q, rx_fe, rx_sh_q}), .rdata(rx_rdata), .count(rx_count), .full(rx_full),
      .empty(rx_empty), .do_push(rx_do_push), .do_pop(rx_do_pop));

   always_comb begin
      tx_st_d  = tx_st_q;
      tx_cnt_d = tx_cnt_q + 1'b1;
      tx_bit_d = tx_bit_q;
      tx_sh_d  = tx_sh_q;
      tx_pop   = 1'b0;
      case (tx_st_q)
         S_IDLE: begin
            tx_cnt_d = '0;
            if (ten & ~tx_empty & ~tclr) begin
               tx_pop  = 1'b1;
               tx_sh_d = tx_rdata;
               tx_st_d = S_START;
            end
         end
         S_START: if (tx_cnt_q == div_eff) begin
            tx_cnt_d = '0;
            tx_bit_d = '0;
            tx_st_d  = S_DATA;
         end
         S_DATA: if (tx_cnt_q == div_eff) begin
            tx_cnt_d = '0;
            tx_bit_d = tx_bit_q + 1'b1;
            if (tx_bit_q == 3'd7) tx_st_d = pen ? S_PAR : S_STOP;
         end
         S_PAR: if (tx_cnt_q == div_eff) begin
            tx_cnt_d = '0;
            tx_bit_d = '0;
            tx_st_d  = S_STOP;
         end
         S_STOP: if (tx_cnt_q == div_eff) begin
            tx_cnt_d = '0;
            tx_bit_d = 3'd1;
            if (!(stop2 & (tx_bit_q == 3'd0))) tx_st_d = S_IDLE;
         end
         default: tx_st_d = S_IDLE;
      endcase
      txd_d = (tx_st_d == S_START) ? 1'b0 : (tx_st_d == S_DATA) ? tx_sh_d[tx_bit_d] :
              (tx_st_d == S_PAR) ? ^tx_sh_d ^ podd : 1'b1;
   end

   // START is sampled half a bit in; later samples land mid-bit at full periods
   always_comb begin
      rxd_d    = {rxd_q[1:0], iUART_RXD};
      rx_st_d  = rx_st_q;
      rx_cnt_d = rx_cnt_q + 1'b1;
      rx_bit_d = rx_bit_q;
      rx_sh_d  = rx_sh_q;
      rx_pe_d  = rx_pe_q;
      rx_push  = 1'b0;
      rx_fe    = 1'b0;
      case (rx_st_q)
         S_IDLE: begin
            rx_cnt_d = '0;
            if (ren & rx_prev & ~rx_line) begin
               rx_pe_d = 1'b0;
               rx_st_d = S_START;
            end
         end
         S_START: if (rx_cnt_q == (div_eff >> 1)) begin
            rx_cnt_d = '0;
            rx_bit_d = '0;
            rx_st_d  = rx_line ? S_IDLE : S_DATA;
         end
         S_DATA: if (rx_cnt_q == div_eff) begin
            rx_cnt_d = '0;
            rx_sh_d  = {rx_line, rx_sh_q[7:1]};
            rx_bit_d = rx_bit_q + 1'b1;
            if (rx_bit_q == 3'd7) rx_st_d = pen ? S_PAR : S_STOP;
         end
         S_PAR: if (rx_cnt_q == div_eff) begin
            rx_cnt_d = '0;
            rx_pe_d  = ^rx_sh_q ^ podd ^ rx_line;
            rx_st_d  = S_STOP;
         end
         S_STOP: if (rx_cnt_q == div_eff) begin
            rx_cnt_d = '0;
            rx_push  = 1'b1;
            rx_fe    = ~rx_line;
            rx_st_d  = S_IDLE;
         end
         default: rx_st_d = S_IDLE;
      endcase
   end

   always_comb begin
      cfg_d     = wr_cfg ? {iREQ_DATA[20:9], 2'b00, iREQ_DATA[6:0]} : cfg_q;
      div_d     = wr_div ? iREQ_DATA[P_DIV_WIDTH-1:0] : div_q;
      stat_d    = (stat_q & ~(wr_stat ? iREQ_DATA[3:0] : 4'h0)) |
                  {tx_ovf, rx_push & rx_pe_q, rx_push & rx_fe, rx_ovf};
      rx_word   = rx_empty ? '0 : {1'b1, 20'h0, rx_rdata[9:8], 1'b0, rx_rdata[7:0]};
      stat_word = {14'h0, rx_st_q != S_IDLE, tx_st_q != S_IDLE, rx_count, tx_count, stat_q};
      rd_val    = (iREQ_ADDR == 3'd1) ? rx_word : (iREQ_ADDR == 3'd2) ? {11'h0, cfg_q} :
                  (iREQ_ADDR == 3'd3) ? stat_word : (iREQ_ADDR == 3'd4) ? 32'(div_q) : '0;
      rvalid_d  = rd;
      rdata_d   = rd ? rd_val : rdata_q;
      irq_d     = ((irq_q == I_IDLE) & (tx_src | rx_src)) ? I_PEND :
                  ((irq_q == I_PEND) & iIRQ_ACK) ? I_WAIT :
                  ((irq_q == I_WAIT) & (~(tx_src | rx_src) | wr_cfg)) ? I_IDLE : irq_q;
   end

   always_ff @(posedge iIF_CLOCK) begin
      if (!inRESET) begin
         cfg_q    <= '0;
         stat_q   <= '0;
         div_q    <= P_BAUDDIV_RST;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         tx_st_q  <= S_IDLE;
         tx_cnt_q <= '0;
         tx_bit_q <= '0;
         tx_sh_q  <= '0;
         txd_q    <= 1'b1;
         rx_st_q  <= S_IDLE;
         rx_cnt_q <= '0;
         rx_bit_q <= '0;
         rx_sh_q  <= '0;
         rx_pe_q  <= 1'b0;
         rxd_q    <= '1;
         irq_q    <= I_IDLE;
      end else begin
         cfg_q    <= cfg_d;
         stat_q   <= stat_d;
         div_q    <= div_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         tx_st_q  <= tx_st_d;
         tx_cnt_q <= tx_cnt_d;
         tx_bit_q <= tx_bit_d;
         tx_sh_q  <= tx_sh_d;
         txd_q    <= txd_d;
         rx_st_q  <= rx_st_d;
         rx_cnt_q <= rx_cnt_d;
         rx_bit_q <= rx_bit_d;
         rx_sh_q  <= rx_sh_d;
         rx_pe_q  <= rx_pe_d;
         rxd_q    <= rxd_d;
         irq_q    <= irq_d;
      end
   end
endmodule

// File: tb/tb_dps_sci_ex.sv
// tb_dps_sci_ex: directed register, TX, loopback RX, FIFO, interrupt and error-path checks
module tb_dps_sci_ex;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        req_valid = 1'b0, req_rw = 1'b0, irq_ack = 1'b0;
   logic [2:0]  req_addr = '0;
   logic [31:0] req_data = '0;
   logic        busy, rsp_valid, irq, tire, rire, txd, rxd;
   logic        loop_en = 1'b0, rxd_drv = 1'b1;
   logic [31:0] rsp_data;
   logic [9:0]  frame;
   logic [7:0]  byte_v;
   int          checks = 0, errors = 0;

   assign rxd = loop_en ? txd : rxd_drv;
   always #5 clk = ~clk;

   dps_sci_ex dut (
      .iIF_CLOCK(clk), .inRESET(rst_n), .iREQ_VALID(req_valid), .oREQ_BUSY(busy),
      .iREQ_RW(req_rw), .iREQ_ADDR(req_addr), .iREQ_DATA(req_data), .oREQ_VALID(rsp_valid),
      .oREQ_DATA(rsp_data), .oIRQ_VALID(irq), .iIRQ_ACK(irq_ack), .oLSFLAGS_TIRE_IRQ(tire),
      .oLSFLAGS_RIRE_IRQ(rire), .oUART_TXD(txd), .iUART_RXD(rxd));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      req_valid = 1'b1; req_rw = 1'b1; req_addr = a; req_data = d;
      tick(1);
      req_valid = 1'b0; req_rw = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
      req_valid = 1'b1; req_rw = 1'b0; req_addr = a;
      tick(1);
      req_valid = 1'b0;
      chk({tag, "_vld"}, 32'(rsp_valid), 32'd1);
      chk(tag, rsp_data, exp);
   endtask

   task automatic ack();
      irq_ack = 1'b1;
      tick(1);
      irq_ack = 1'b0;
   endtask

   task automatic send_bit(input logic b);
      rxd_drv = b;
      tick(4);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "timeout");
   end

   initial begin
      tick(2);
      chk("rst_txd", 32'(txd), 32'd1);
      chk("rst_rdata", rsp_data, 32'd0);
      chk("rst_rvalid", 32'(rsp_valid), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_flags", {30'd0, tire, rire}, 32'd0);
      rst_n = 1'b1;
      rd("rst_status", 3'd3, 32'd0);
      rd("rst_baud", 3'd4, 32'd433);
      rd("rst_cfg", 3'd2, 32'd0);
      rd("addr5", 3'd5, 32'd0);
      tick(1);
      chk("rvalid_pulse", 32'(rsp_valid), 32'd0);

      // TX frame of 0xA5, 4 clocks per bit
      wr(3'd4, 32'd3);
      wr(3'd2, 32'h1);
      wr(3'd0, 32'hA5);
      frame = {1'b1, 8'hA5, 1'b0};
      for (int i = 0; i < 40; i++) begin
         tick(1);
         chk("tx_a5_bit", 32'(txd), 32'(frame[i / 4]));
      end
      rd("tx_busy_last", 3'd3, 32'h1_0000);
      rd("tx_busy_clear", 3'd3, 32'h0);

      // loopback with even parity
      loop_en = 1'b1;
      wr(3'd2, 32'h7);
      wr(3'd0, 32'h3C);
      tick(60);
      rd("lb_status", 3'd3, 32'h400);
      rd("lb_rxdata", 3'd1, 32'h8000_003C);
      rd("lb_status2", 3'd3, 32'h0);
      rd("rx_empty_read", 3'd1, 32'h0);

      // TX FIFO fill, overflow, W1C, flush
      wr(3'd2, 32'h0);
      for (int i = 0; i < 15; i++) wr(3'd0, 32'(i));
      chk("busy_15", 32'(busy), 32'd0);
      wr(3'd0, 32'h0F);
      chk("busy_16", 32'(busy), 32'd1);
      wr(3'd0, 32'hFF);
      rd("ovf_status", 3'd3, 32'h108);
      wr(3'd3, 32'h8);
      rd("ovf_w1c", 3'd3, 32'h100);
      wr(3'd2, 32'h80);
      rd("tclr_status", 3'd3, 32'h0);
      rd("tclr_cfg", 3'd2, 32'h0);
      chk("busy_flushed", 32'(busy), 32'd0);

      // RX threshold interrupt
      wr(3'd2, 32'h1_0043);
      rd("thr_cfg", 3'd2, 32'h1_0043);
      wr(3'd0, 32'h11);
      wr(3'd0, 32'h22);
      tick(100);
      chk("thr_irq", 32'(irq), 32'd1);
      chk("thr_flags", {30'd0, tire, rire}, 32'd1);
      ack();
      chk("thr_acked", 32'(irq), 32'd0);
      tick(5);
      chk("thr_wait", 32'(irq), 32'd0);
      rd("thr_pop", 3'd1, 32'h8000_0011);
      wr(3'd0, 32'h33);
      tick(60);
      chk("thr_reraise", 32'(irq), 32'd1);
      rd("thr_status", 3'd3, 32'h800);
      ack();
      rd("thr_pop2", 3'd1, 32'h8000_0022);
      rd("thr_pop3", 3'd1, 32'h8000_0033);

      // injected frame with a low stop bit
      loop_en = 1'b0;
      wr(3'd2, 32'h42);
      byte_v = 8'h5A;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(byte_v[i]);
      send_bit(1'b0);
      rxd_drv = 1'b1;
      tick(10);
      chk("fe_irq", 32'(irq), 32'd1);
      rd("fe_status", 3'd3, 32'h402);
      rd("fe_rxdata", 3'd1, 32'h8000_025A);
      wr(3'd3, 32'h2);
      ack();
      rd("fe_cleared", 3'd3, 32'h0);
      rxd_drv = 1'b0;
      tick(1);
      rxd_drv = 1'b1;
      tick(20);
      rd("glitch_status", 3'd3, 32'h0);
      chk("glitch_irq", 32'(irq), 32'd0);

      // divisor below 3 clamps to 4-clock bits, then reset mid-frame
      wr(3'd4, 32'd0);
      wr(3'd2, 32'h1);
      wr(3'd0, 32'h01);
      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk("min_div_bit", 32'(txd), (i < 4) ? 32'd0 : 32'd1);
      end
      tick(4);
      chk("pre_reset_txd", 32'(txd), 32'd0);
      rst_n = 1'b0;
      tick(1);
      chk("midframe_rst_txd", 32'(txd), 32'd1);
      rst_n = 1'b1;
      rd("midframe_rst_baud", 3'd4, 32'd433);
      rd("midframe_rst_status", 3'd3, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/dps_sci_ex.md
Name: dps_sci_ex

Overview:
Parametrised next-generation SCI for the DPS device bus. It integrates its own UART TX/RX engines, depth-parametrised FIFOs, a programmable baud divisor, optional parity and two-stop-bit mode, sticky error flags, and threshold-programmable level interrupts. It sits behind the DPS CPU request interface and drives one UART pin pair.

Parameters:
P_FIFO_DEPTH_N, 4, log2 of each FIFO depth; legal range 2..5 (4..32 entries).
P_DIV_WIDTH, 16, width of the baud divisor register.
P_BAUDDIV_RST, 16'd433, reset value of BAUDDIV.

Ports:
iIF_CLOCK  in  1  sole clock.
inRESET  in  1  reset; synchronous, active-low.
iREQ_VALID  in  1  request strobe, single cycle.
oREQ_BUSY  out  1  TX FIFO full.
iREQ_RW  in  1  1 = write, 0 = read.
iREQ_ADDR  in  3  register select.
iREQ_DATA  in  32  write data.
oREQ_VALID  out  1  read response strobe.
oREQ_DATA  out  32  read response data.
oIRQ_VALID  out  1  interrupt request, held until acknowledged.
iIRQ_ACK  in  1  interrupt acknowledge.
oLSFLAGS_TIRE_IRQ  out  1  TX-level source, raw.
oLSFLAGS_RIRE_IRQ  out  1  RX-level or error source, raw.
oUART_TXD  out  1  serial out, idle high.
iUART_RXD  in  1  serial in, asynchronous.

Behaviour:
- Reset is sampled only on a iIF_CLOCK edge with inRESET=0. Reset values: oUART_TXD=1, oREQ_VALID=0, oREQ_DATA=0, oIRQ_VALID=0, both LSFLAGS=0, oREQ_BUSY=0, FIFOs empty, CFG=0, STATUS flags=0, BAUDDIV=P_BAUDDIV_RST. Reset mid-frame aborts both engines immediately; TXD returns to 1 on the next edge.
- Register map:
  - 0 TXDATA (W): [7:0] pushed to the TX FIFO.
  - 1 RXDATA (R): returns {1'b1, 20'h0, PE, FE, 0, data[7:0]} and pops; if the FIFO is empty, returns 0 and does not pop.
  - 2 CFG (RW):
    - [0] TEN, [1] REN, [2] PEN, [3] PODD, [4] STOP2, [5] TIE, [6] RIE.
    - [7] TCLR and [8] RCLR flush the respective FIFO for one cycle; they always read back 0.
    - [14:9] TXTHR, [20:15] RXTHR.
  - 3 STATUS (R; W1C on [3:0]): [0] RX overrun, [1] framing error, [2] parity error, [3] TX overflow, [9:4] TX count, [15:10] RX count, [16] TX busy, [17] RX busy.
  - 4 BAUDDIV (RW). Addresses 5–7: reads return 0, writes are ignored.
- Read latency is exactly 1 cycle: oREQ_VALID pulses one cycle after any read request. Writes produce no response.
- A TXDATA write while the FIFO is full is dropped and sets STATUS[3]. oREQ_BUSY is combinational from FIFO full.
- Simultaneous push and pop on a full or empty FIFO: on empty, push only; on full, both occur and the count is unchanged. A flush wins over a same-cycle push or pop.
- Bit period is BAUDDIV+1 clocks. Values below 3 are treated as 3.
- TX FSM: IDLE → START → DATA(8 bits, LSB first) → PARITY (only if PEN) → STOP (1 or 2 bits) → IDLE.
  - Leaves IDLE when TEN=1 and the FIFO is not empty; the pop happens on the IDLE→START cycle.
  - Clearing TEN mid-frame completes the current frame.
  - Parity bit = XOR of the data bits, inverted when PODD.
- RX path: iUART_RXD passes through a 2-FF synchroniser, adding 2 cycles of latency.
- RX FSM: IDLE → START → DATA → PARITY (only if PEN) → STOP → IDLE.
  - IDLE→START on a falling edge while REN=1.
  - START samples at (BAUDDIV+1)/2 clocks; if the line is high, return to IDLE (glitch rejection).
  - Subsequent samples occur at full bit periods.
  - STOP sampled low sets FE. A parity mismatch sets PE. The byte and its PE/FE are still pushed with the data.
  - RX FIFO full at push: byte dropped, STATUS[0] set. Only the first stop bit is checked.
- Interrupt sources, combinational and level-sensitive:
  - TX source = TIE & (txcount ≤ TXTHR).
  - RX source = RIE & ((RXTHR≠0 & rxcount ≥ RXTHR) | STATUS[2:0]≠0).
- IRQ FSM:
  - IDLE → PEND when either source is high; oIRQ_VALID=1 in PEND.
  - PEND → WAIT on iIRQ_ACK.
  - WAIT → IDLE when both sources are low, or on any CFG write.
  - An ACK in IDLE or WAIT is ignored.
- Count and threshold arithmetic is unsigned, 6 bits. A threshold above the depth never matches for RX, and always matches for TX.

Test Plan:
- Reset: hold inRESET=0 for 2 edges → TXD=1, oREQ_DATA=0, STATUS reads 0, BAUDDIV reads 433.
- BAUDDIV=3, CFG=0x1, write 0xA5 → TXD shows start bit, then 1,0,1,0,0,1,0,1, then stop; each bit 4 clocks; TX busy clears after 40 clocks.
- Loopback TXD→RXD, PEN=1, PODD=0, REN=1, send 0x3C → RXDATA read one cycle later returns 0x8000003C; STATUS PE=0, FE=0.
- Fill the TX FIFO (16 writes, TEN=0), then a 17th write → oREQ_BUSY=1, STATUS=0x108 (TX count 16, overflow); writing 0x8 to STATUS clears bit 3.
- RXTHR=2, RIE=1, receive 2 bytes → oIRQ_VALID rises; ACK → low and stays low; pop one byte → source drops → IDLE; a third byte re-raises the IRQ.
- Inject an RX frame with stop bit 0 → FE set, IRQ asserted with RIE=1; also inject a 1-clock low glitch in IDLE → no byte received.
